// File: rtl/fifo_rd_drain.sv
// Read-side drain for an asynchronous FIFO: issues reads while space remains downstream,
// absorbs the one-cycle read latency in a circular skid buffer and presents a valid/ready stream.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_rd,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    localparam int PTR_W = (SKID_DEPTH > 2) ? 2 : 1;
    localparam int OCC_W = 4;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(SKID_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] skid [SKID_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      skid_cnt;
    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign m_valid = (skid_cnt != '0);
    assign pop     = m_valid && m_ready;
    // Occupancy after this edge: counting a same-cycle pop keeps rd_en high at full rate.
    assign occ     = skid_cnt + OCC_W'(inflight) - OCC_W'(pop);
    assign rd_en   = en && !empty && !rst && (occ < DEPTH_OCC);
    assign m_data  = m_valid ? skid[head] : '0;
    assign busy    = inflight || m_valid;

    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                rd_count <= rd_count + 1'b1;
            end
            if (inflight) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            if (inflight && !pop) begin
                skid_cnt <= skid_cnt + 1'b1;
            end else if (!inflight && pop) begin
                skid_cnt <= skid_cnt - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted in skid_cnt.
    always_ff @(posedge clk_rd) begin
        if (inflight) begin
            skid[tail] <= data_out;
        end
    end

endmodule
